// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

    // Default data/address width of the pipeline.
    localparam int unsigned DefaultWidth = 32;

    // Arbiter FSM states; encodings are fixed so the hazard logic can decode them.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBusyI = 2'b01,
        StBusyD = 2'b10
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory.
// Data has priority; a burst counter bounds consecutive data grants while a fetch
// waits. Every transaction is followed by one IDLE recovery cycle carrying the
// done pulse, so requesters can drop or renew before the next grant decision.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    // Instruction fetch port
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_done,
    // Data port
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_done,
    // Memory side
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    // Pipeline stalls
    output logic             stall_if,
    output logic             stall_mem
);

    localparam int unsigned     CntW      = $clog2(BURST_MAX + 1);
    localparam logic [CntW-1:0] BurstMaxC = CntW'(BURST_MAX);

    arb_state_e       r_state,     w_state_nxt;
    logic             r_mem_req,   w_mem_req_nxt;
    logic             r_mem_we,    w_mem_we_nxt;
    logic [WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [WIDTH-1:0] r_if_rdata,  w_if_rdata_nxt;
    logic [WIDTH-1:0] r_dm_rdata,  w_dm_rdata_nxt;
    logic             r_if_done,   w_if_done_nxt;
    logic             r_dm_done,   w_dm_done_nxt;
    logic [CntW-1:0]  r_burst_cnt, w_burst_cnt_nxt;

    logic             w_grant_ok;
    logic             w_dm_grant;
    logic             w_if_grant;

    // Grant decision: only in IDLE and never in the cycle a done pulse is out.
    always_comb begin
        w_grant_ok = (r_state == StIdle) && !r_if_done && !r_dm_done;
        w_dm_grant = w_grant_ok && dm_req && (!if_req || (r_burst_cnt < BurstMaxC));
        w_if_grant = w_grant_ok && if_req && !w_dm_grant;
    end

    // Next-state, memory-side drive, read-data capture and burst counter.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_if_done_nxt   = 1'b0;
        w_dm_done_nxt   = 1'b0;
        w_burst_cnt_nxt = r_burst_cnt;

        case (r_state)
            StIdle: begin
                // mem_ack here is stray and deliberately ignored.
                if (w_dm_grant) begin
                    w_state_nxt     = StBusyD;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = dm_we;
                    w_mem_addr_nxt  = dm_addr;
                    w_mem_wdata_nxt = dm_wdata;
                    if (!if_req) begin
                        w_burst_cnt_nxt = '0;
                    end else if (r_burst_cnt != BurstMaxC) begin
                        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                    end
                end else if (w_if_grant) begin
                    w_state_nxt     = StBusyI;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_burst_cnt_nxt = '0;
                end
            end
            StBusyI: begin
                if (mem_ack) begin
                    w_state_nxt    = StIdle;
                    w_mem_req_nxt  = 1'b0;
                    w_if_rdata_nxt = mem_rdata;
                    w_if_done_nxt  = 1'b1;
                end
            end
            StBusyD: begin
                if (mem_ack) begin
                    w_state_nxt   = StIdle;
                    w_mem_req_nxt = 1'b0;
                    if (!r_mem_we) begin
                        w_dm_rdata_nxt = mem_rdata;
                    end
                    w_dm_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt   = StIdle;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_dm_done   <= w_dm_done_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;

    // Only combinational input-to-output paths in the block.
    assign stall_if  = if_req & ~r_if_done;
    assign stall_mem = dm_req & ~r_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(
        .WIDTH     (32),
        .BURST_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set here apply to that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic is_f [6];
    int   grants;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_we), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_dm_rdata",  dm_rdata, 32'd0);
        check("rst_if_done",   32'(if_done), 32'd0);
        check("rst_dm_done",   32'(dm_done), 32'd0);
        check("rst_stall_if",  32'(stall_if), 32'd0);

        // Lone fetch, L=0.
        tick();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        check("lf_stall_c0", 32'(stall_if), 32'd1);
        check("lf_req_c0",   32'(mem_req), 32'd0);
        tick();
        check("lf_req_c1",   32'(mem_req), 32'd1);
        check("lf_we_c1",    32'(mem_we), 32'd0);
        check("lf_addr_c1",  mem_addr, 32'h40);
        check("lf_stall_c1", 32'(stall_if), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
        tick();
        mem_ack = 1'b0;
        #1;
        check("lf_done_c2",  32'(if_done), 32'd1);
        check("lf_rdata_c2", if_rdata, 32'h8C01_0004);
        check("lf_req_c2",   32'(mem_req), 32'd0);
        check("lf_stall_c2", 32'(stall_if), 32'd0);
        if_req = 1'b0;
        tick();
        check("lf_done_c3",  32'(if_done), 32'd0);

        // Data read, L=1, to give dm_rdata a known value.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
        tick();
        check("rd_req_c1", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        #1;
        check("rd_done",  32'(dm_done), 32'd1);
        check("rd_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 1'b0;
        tick();

        // Data write, L=3: mem lines stable for 4 cycles, done in cycle 5.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        #1;
        check("wr_stall_c0", 32'(stall_mem), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("wr_req",   32'(mem_req), 32'd1);
            check("wr_we",    32'(mem_we), 32'd1);
            check("wr_addr",  mem_addr, 32'h100);
            check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("wr_nodone", 32'(dm_done), 32'd0);
            if (k == 4) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end
        end
        tick();
        mem_ack = 1'b0;
        #1;
        check("wr_done_c5",  32'(dm_done), 32'd1);
        check("wr_rdata",    dm_rdata, 32'hCAFE_F00D);
        check("wr_stall_c5", 32'(stall_mem), 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        check("wr_done_c6", 32'(dm_done), 32'd0);

        // Collision: data first, fetch granted the cycle after dm_done.
        if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        tick();
        check("col_addr_c1", mem_addr, 32'h200);
        check("col_req_c1",  32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        #1;
        check("col_dmdone_c2", 32'(dm_done), 32'd1);
        check("col_dmrd_c2",   dm_rdata, 32'h1111_2222);
        check("col_req_c2",    32'(mem_req), 32'd0);
        check("col_stallif",   32'(stall_if), 32'd1);
        dm_req = 1'b0;
        tick();
        check("col_req_c3", 32'(mem_req), 32'd0);
        tick();
        check("col_req_c4",  32'(mem_req), 32'd1);
        check("col_addr_c4", mem_addr, 32'h44);
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        tick();
        mem_ack = 1'b0;
        #1;
        check("col_ifdone_c5", 32'(if_done), 32'd1);
        check("col_ifrd_c5",   if_rdata, 32'h3333_4444);
        if_req = 1'b0;
        tick();

        // Starvation guard: expect D D D D I D with L=0 acks.
        if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
        grants = 0;
        for (int c = 0; c < 60 && grants < 6; c++) begin
            tick();
            if (mem_req) begin
                is_f[grants] = (mem_addr == 32'h80);
                if (grants == 3) check("sv_cnt_sat", 32'(dut.r_burst_cnt), 32'd4);
                if (grants == 4) check("sv_cnt_clr", 32'(dut.r_burst_cnt), 32'd0);
                grants++;
                mem_ack = 1'b1; mem_rdata = 32'h5555_0000 + 32'(c);
            end else begin
                mem_ack = 1'b0;
            end
        end
        check("sv_grants", 32'(grants), 32'd6);
        check("sv_seq", {26'd0, is_f[0], is_f[1], is_f[2], is_f[3], is_f[4], is_f[5]},
              32'b000010);
        tick();
        mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        tick(); tick();

        // Reset while BUSY_D before the ack.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'hA5A5_A5A5;
        tick();
        check("rm_req_c1", 32'(mem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        #1;
        check("rm_state", 32'(dut.r_state), 32'd0);
        check("rm_req",   32'(mem_req), 32'd0);
        check("rm_done",  32'(dm_done), 32'd0);
        mem_ack = 1'b1;
        tick();
        check("rm_stray_done", 32'(dm_done), 32'd0);
        check("rm_stray_req",  32'(mem_req), 32'd0);

        // Spurious ack in IDLE with no requests.
        mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        check("sp_state",   32'(dut.r_state), 32'd0);
        check("sp_ifdone",  32'(if_done), 32'd0);
        check("sp_dmdone",  32'(dm_done), 32'd0);
        check("sp_ifrdata", if_rdata, 32'd0);
        check("sp_dmrdata", dm_rdata, 32'd0);
        check("sp_addr",    mem_addr, 32'd0);
        mem_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
